// File: rtl/hex_seg_decoder.sv
// hex_seg_decoder: reads back time-multiplexed active-low 7-segment digits, filters each
// digit for stability, decodes to nibbles and hands out whole frames over valid/ready.
module hex_seg_decoder #(
    parameter int NUM_DIGITS = 2,
    parameter int STABLE_CNT = 4,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CW = $clog2(STABLE_CNT + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic                    seg_strobe,
    input  logic [IW-1:0]           digit_idx,
    output logic [4*NUM_DIGITS-1:0] out_value,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_pattern,
    output logic                    overrun
);
    localparam logic [CW-1:0] FULL = CW'(STABLE_CNT);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [IW:0]   ND   = (IW + 1)'(NUM_DIGITS);

    logic [NUM_DIGITS-1:0][6:0]    last_pat;
    logic [NUM_DIGITS-1:0][CW-1:0] cnt;
    logic [NUM_DIGITS-1:0]         done, done_n;
    logic [NUM_DIGITS-1:0][3:0]    nib, nib_n;
    logic                          sel, same, confirm, complete, dec_ok;
    logic [CW-1:0]                 old_cnt, new_cnt;
    logic [3:0]                    dec_val;

    // {valid, nibble}; only exact table matches decode
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40: decode = 5'h10;
            7'h79: decode = 5'h11;
            7'h24: decode = 5'h12;
            7'h30: decode = 5'h13;
            7'h19: decode = 5'h14;
            7'h12: decode = 5'h15;
            7'h02: decode = 5'h16;
            7'h78: decode = 5'h17;
            7'h00: decode = 5'h18;
            7'h10: decode = 5'h19;
            7'h08: decode = 5'h1A;
            7'h03: decode = 5'h1B;
            7'h46: decode = 5'h1C;
            7'h21: decode = 5'h1D;
            7'h06: decode = 5'h1E;
            7'h0E: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        sel      = seg_strobe && ({1'b0, digit_idx} < ND);
        same     = seg_in == last_pat[digit_idx];
        old_cnt  = cnt[digit_idx];
        new_cnt  = !same ? ONE : (old_cnt == FULL) ? FULL : old_cnt + ONE;
        // a changed pattern always restarts the count, so it may confirm when STABLE_CNT=1
        confirm  = sel && (new_cnt == FULL) && (!same || old_cnt != FULL);
        {dec_ok, dec_val} = decode(seg_in);
        done_n   = done;
        nib_n    = nib;
        if (confirm) begin
            done_n[digit_idx] = dec_ok;
            if (dec_ok)
                nib_n[digit_idx] = dec_val;
        end
        complete = &done_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pat    <= {NUM_DIGITS{7'h7F}};
            cnt         <= '0;
            done        <= '0;
            nib         <= '0;
            out_value   <= '0;
            out_valid   <= 1'b0;
            err_pattern <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (sel) begin
                last_pat[digit_idx] <= seg_in;
                cnt[digit_idx]      <= new_cnt;
            end
            nib         <= nib_n;
            done        <= complete ? '0 : done_n;
            err_pattern <= confirm && !dec_ok;
            overrun     <= complete && out_valid && !out_ready;
            if (complete && (!out_valid || out_ready)) begin
                out_value <= nib_n;
                out_valid <= 1'b1;
            end else if (!complete && out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hex_seg_decoder.sv
// tb_hex_seg_decoder: directed scenarios plus random traffic, checked every cycle
// against a table-driven behavioural model of the decoder.
module tb_hex_seg_decoder;
    localparam int STB = 4;

    logic       clk, rst_n, seg_strobe, out_ready;
    logic [6:0] seg_in;
    logic [0:0] digit_idx;
    logic [7:0] out_value;
    logic       out_valid, err_pattern, overrun;

    int total = 0, bad = 0;
    bit chk_en = 0;

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int         m_last [2], m_cnt [2], m_nib [2];
    bit         m_done [2];
    logic [7:0] m_val;
    bit         m_vld, m_err, m_ovr;

    hex_seg_decoder #(.NUM_DIGITS(2), .STABLE_CNT(STB)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .seg_strobe(seg_strobe),
        .digit_idx(digit_idx), .out_value(out_value), .out_valid(out_valid),
        .out_ready(out_ready), .err_pattern(err_pattern), .overrun(overrun)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic int dec(input int p);
        for (int i = 0; i < 16; i++)
            if (int'(tbl[i]) == p) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        int l [2], c [2], nb [2];
        bit dn [2];
        logic [7:0] v;
        bit vl, e, o, conf;
        int d, nc, dv, oc;
        if (!rst_n) begin
            m_last <= '{127, 127};
            m_cnt  <= '{0, 0};
            m_nib  <= '{0, 0};
            m_done <= '{0, 0};
            m_val  <= 8'h00;
            m_vld  <= 0;
            m_err  <= 0;
            m_ovr  <= 0;
        end else begin
            l = m_last; c = m_cnt; nb = m_nib; dn = m_done;
            v = m_val; vl = m_vld; e = 0; o = 0; conf = 0;
            if (seg_strobe && int'(digit_idx) < 2) begin
                d  = int'(digit_idx);
                oc = c[d];
                if (int'(seg_in) == l[d]) begin
                    nc   = (oc + 1 > STB) ? STB : oc + 1;
                    conf = (nc == STB) && (oc != STB);
                end else begin
                    l[d] = int'(seg_in);
                    nc   = 1;
                    conf = (nc == STB);
                end
                c[d] = nc;
                if (conf) begin
                    dv = dec(int'(seg_in));
                    if (dv >= 0) begin
                        nb[d] = dv;
                        dn[d] = 1;
                    end else begin
                        dn[d] = 0;
                        e = 1;
                    end
                end
            end
            if (dn[0] && dn[1]) begin
                dn = '{0, 0};
                if (!vl || out_ready) begin
                    v  = 8'(nb[1] * 16 + nb[0]);
                    vl = 1;
                end else o = 1;
            end else if (vl && out_ready) vl = 0;
            m_last <= l; m_cnt <= c; m_nib <= nb; m_done <= dn;
            m_val <= v; m_vld <= vl; m_err <= e; m_ovr <= o;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_value", 32'(out_value), 32'(m_val));
            chk("model_valid", 32'(out_valid), 32'(m_vld));
            chk("model_err", 32'(err_pattern), 32'(m_err));
            chk("model_overrun", 32'(overrun), 32'(m_ovr));
        end
    end

    task automatic do_reset();
        seg_strobe = 0;
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic strobe(input int idx, input logic [6:0] s, input int n);
        repeat (n) begin
            seg_in = s;
            digit_idx = 1'(idx);
            seg_strobe = 1;
            @(negedge clk);
        end
        seg_strobe = 0;
    endtask

    task automatic idle();
        seg_strobe = 0;
        @(negedge clk);
    endtask

    initial begin : stim
        logic [6:0] pool [6] = '{7'h40, 7'h79, 7'h24, 7'h7F, 7'h12, 7'h0E};
        logic [6:0] cur [2] = '{7'h40, 7'h79};
        int d;
        rst_n = 0; seg_in = 7'h7F; digit_idx = 0; seg_strobe = 0; out_ready = 1;
        @(negedge clk);
        do_reset();
        chk_en = 1;
        chk("reset_value", 32'(out_value), 32'h0);
        chk("reset_valid", 32'(out_valid), 32'h0);
        // T1
        strobe(0, 7'h19, 4);
        strobe(1, 7'h24, 4);
        chk("t1_value", 32'(out_value), 32'h24);
        chk("t1_valid", 32'(out_valid), 32'h1);
        idle();
        chk("t1_valid_drop", 32'(out_valid), 32'h0);
        // T2
        strobe(1, 7'h79, 4);
        strobe(0, 7'h19, 3);
        strobe(0, 7'h12, 3);
        chk("t2_no_early", 32'(out_valid), 32'h0);
        strobe(0, 7'h12, 1);
        chk("t2_valid", 32'(out_valid), 32'h1);
        chk("t2_value", 32'(out_value), 32'h15);
        idle();
        // T3
        strobe(0, 7'h7F, 4);
        chk("t3_err", 32'(err_pattern), 32'h1);
        idle();
        chk("t3_err_pulse", 32'(err_pattern), 32'h0);
        strobe(1, 7'h30, 4);
        chk("t3_no_frame", 32'(out_valid), 32'h0);
        // T4
        do_reset();
        out_ready = 0;
        strobe(0, 7'h24, 4);
        strobe(1, 7'h19, 4);
        chk("t4_value", 32'(out_value), 32'h42);
        strobe(0, 7'h10, 4);
        strobe(1, 7'h10, 4);
        chk("t4_overrun", 32'(overrun), 32'h1);
        chk("t4_kept", 32'(out_value), 32'h42);
        out_ready = 1;
        idle();
        chk("t4_overrun_pulse", 32'(overrun), 32'h0);
        chk("t4_drop", 32'(out_valid), 32'h0);
        // T5
        do_reset();
        out_ready = 0;
        strobe(0, 7'h24, 4);
        strobe(1, 7'h19, 4);
        strobe(0, 7'h46, 4);
        strobe(1, 7'h30, 3);
        out_ready = 1;
        strobe(1, 7'h30, 1);
        chk("t5_valid", 32'(out_valid), 32'h1);
        chk("t5_value", 32'(out_value), 32'h3C);
        chk("t5_no_overrun", 32'(overrun), 32'h0);
        idle();
        // T6
        do_reset();
        out_ready = 0;
        strobe(0, 7'h79, 4);
        strobe(1, 7'h79, 4);
        strobe(0, 7'h40, 4);
        chk("t6_pre_valid", 32'(out_valid), 32'h1);
        #2 rst_n = 0;
        #1;
        chk("t6_async_value", 32'(out_value), 32'h0);
        chk("t6_async_valid", 32'(out_valid), 32'h0);
        chk("t6_async_pulses", 32'({err_pattern, overrun}), 32'h0);
        @(negedge clk);
        rst_n = 1;
        strobe(1, 7'h24, 4);
        idle();
        chk("t6_no_frame", 32'(out_valid), 32'h0);
        // random traffic against the model
        repeat (3000) begin
            d = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) cur[d] = pool[$urandom_range(0, 5)];
            seg_in = cur[d];
            digit_idx = 1'(d);
            seg_strobe = $urandom_range(0, 4) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            @(negedge clk);
        end
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
